dp_edit_blinker: RTL

- Sequential successor to the combinational decimal-point selector of the 7-segment clock display.
- Owns the adjust-mode state itself: a mode button steps through the editable fields (seconds, minutes, hours, ...).
- The decimal point of the field being edited blinks. An idle timeout drops back to normal run mode.
- Sits between the debounced button pulses and the display scan driver; dp_o feeds the DP segment bits of the scanner.

---
 rtl/dp_edit_blinker_if.sv | 16 +
 rtl/dp_edit_blinker.sv | 134 +++++++++++++
 2 files changed

// File: rtl/dp_edit_blinker_if.sv
// Button-pulse inputs and display outputs of the decimal-point edit blinker.
// master = button/control side, slave = dp_edit_blinker.
interface dp_edit_blinker_if #(
  parameter int N_DIGITS = 12,
  parameter int N_FIELDS = 3
);
  localparam int FW = $clog2(N_FIELDS + 1);

  logic                mode_btn;
  logic                activity;
  logic [FW-1:0]       mode_o;
  logic [N_DIGITS-1:0] dp_o;

  modport master (output mode_btn, output activity, input mode_o, input dp_o);
  modport slave  (input mode_btn, input activity, output mode_o, output dp_o);
endinterface

// File: rtl/dp_edit_blinker.sv
// Adjust-mode FSM with blinking decimal point on the edited field and idle timeout.
// Optional `DP_HEARTBEAT_EN: free-running seconds heartbeat on bit FIELD_BASE in run mode.
module dp_edit_blinker #(
  parameter int N_DIGITS     = 12,
  parameter int N_FIELDS     = 3,
  parameter int FIELD_BASE   = 3,
  parameter int FIELD_STRIDE = 3,
  parameter int BLINK_HALF   = 25000000,
  parameter int IDLE_TIMEOUT = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  dp_edit_blinker_if.slave bus
);
  localparam int FW = $clog2(N_FIELDS + 1);
  localparam int CW = $clog2(BLINK_HALF);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [FW-1:0] LAST_FIELD = FW'(N_FIELDS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(BLINK_HALF - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(IDLE_TIMEOUT - 1);

  if (FIELD_BASE + (N_FIELDS - 1) * FIELD_STRIDE >= N_DIGITS) begin : g_bad_index
    $error("dp_edit_blinker: DP index of last field exceeds N_DIGITS-1");
  end
  if (BLINK_HALF < 2 || IDLE_TIMEOUT < 1 || N_FIELDS < 1) begin : g_bad_timing
    $error("dp_edit_blinker: need BLINK_HALF >= 2, IDLE_TIMEOUT >= 1, N_FIELDS >= 1");
  end

  typedef enum logic {S_RUN, S_EDIT} state_t;

  state_t              state, state_n;
  logic [FW-1:0]       field, field_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                phase, phase_n;
  logic [TW-1:0]       tcnt, tcnt_n;
  logic [N_DIGITS-1:0] dp_q, dp_n;
  logic                term;

  function automatic logic [N_DIGITS-1:0] field_mask(input int unsigned f);
    logic [N_DIGITS-1:0] one;
    one = N_DIGITS'(1);
    return one << (FIELD_BASE + (f - 1) * FIELD_STRIDE);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
      field <= '0;
      cnt   <= '0;
      phase <= 1'b1;
      tcnt  <= '0;
      dp_q  <= '0;
    end else begin
      state <= state_n;
      field <= field_n;
      cnt   <= cnt_n;
      phase <= phase_n;
      tcnt  <= tcnt_n;
      dp_q  <= dp_n;
    end
  end

  assign term = (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    field_n = field;
    cnt_n   = cnt;
    phase_n = phase;
    tcnt_n  = tcnt;
    dp_n    = '0;

    // mode_btn outranks both activity and a coincident timeout
    if (bus.mode_btn) begin
      if (state == S_RUN) begin
        state_n = S_EDIT;
        field_n = FW'(1);
      end else if (field == LAST_FIELD) begin
        state_n = S_RUN;
        field_n = '0;
      end else begin
        field_n = field + 1'b1;
      end
      cnt_n   = '0;
      phase_n = 1'b1;
      tcnt_n  = '0;
    end else if (state == S_EDIT) begin
      if (bus.activity) begin
        cnt_n   = '0;
        phase_n = 1'b1;
        tcnt_n  = '0;
      end else if (term) begin
        cnt_n   = '0;
        if (tcnt == TO_LAST) begin
          state_n = S_RUN;
          field_n = '0;
          phase_n = 1'b1;
          tcnt_n  = '0;
        end else begin
          phase_n = ~phase;
          tcnt_n  = tcnt + 1'b1;
        end
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end else begin
`ifdef DP_HEARTBEAT_EN
      if (term) begin
        cnt_n   = '0;
        phase_n = ~phase;
      end else begin
        cnt_n = cnt + 1'b1;
      end
`else
      cnt_n   = '0;
      phase_n = 1'b1;
`endif
      tcnt_n = '0;
    end

    // dp is registered from next-state values so it changes with mode_o
    if (state_n == S_EDIT && phase_n) begin
      for (int unsigned f = 1; f <= N_FIELDS; f++) begin
        if (field_n == FW'(f)) dp_n = field_mask(f);
      end
    end
`ifdef DP_HEARTBEAT_EN
    if (state_n == S_RUN && phase_n) dp_n = field_mask(1);
`endif
  end

  assign bus.mode_o = field;
  assign bus.dp_o   = dp_q;
endmodule
